// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage: PC, imem req/ack handshake, instruction register
module instr_fetch #(
    parameter int ADDR_W              = 8,
    parameter int INSTR_W             = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fetch_en,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               id_ce,
    input  logic               exec_done,
    input  logic               jump,
    input  logic [ADDR_W-1:0]  jump_addr,
    output logic [ADDR_W-1:0]  pc
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        DECODE = 2'd2
    } state_t;

    state_t state;

    // The address bus is the PC itself; it only matters while imem_req is high.
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            instr    <= '0;
            imem_req <= 1'b0;
            id_ce    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fetch_en) begin
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end
                end
                FETCH: begin
                    // Request stays up until acknowledged, even if fetch_en drops meanwhile.
                    if (imem_ack) begin
                        instr    <= imem_rdata;
                        imem_req <= 1'b0;
                        id_ce    <= 1'b1;
                        state    <= DECODE;
                    end
                end
                DECODE: begin
                    if (exec_done) begin
                        pc    <= jump ? jump_addr : pc + 1'b1;
                        id_ce <= 1'b0;
                        if (fetch_en) begin
                            state    <= FETCH;
                            imem_req <= 1'b1;
                        end else begin
                            state    <= IDLE;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                    id_ce    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed and randomized check of instr_fetch against a reference model
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        fetch_en = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic [15:0] instr;
    logic        id_ce;
    logic        exec_done = 1'b0;
    logic        jump = 1'b0;
    logic [7:0]  jump_addr = '0;
    logic [7:0]  pc;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: the expected outputs double as the stage's observable status.
    logic        exp_req;
    logic        exp_ce;
    logic [15:0] exp_instr;
    logic [7:0]  exp_pc;

    instr_fetch #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .id_ce(id_ce),
        .exec_done(exec_done), .jump(jump), .jump_addr(jump_addr),
        .pc(pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        exp_req = 1'b0; exp_ce = 1'b0; exp_instr = '0; exp_pc = 8'h00;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".req"},   {31'd0, imem_req}, {31'd0, exp_req});
        check({tag, ".ce"},    {31'd0, id_ce},    {31'd0, exp_ce});
        check({tag, ".instr"}, {16'd0, instr},    {16'd0, exp_instr});
        check({tag, ".pc"},    {24'd0, pc},       {24'd0, exp_pc});
        if (exp_req) check({tag, ".addr"}, {24'd0, imem_addr}, {24'd0, exp_pc});
    endtask

    // Drive one cycle of inputs, predict the edge, then compare 1 time unit after it.
    task automatic cycle(input string tag, input logic fe, input logic ack, input logic [15:0] rd,
                         input logic done, input logic jmp, input logic [7:0] ja);
        fetch_en = fe; imem_ack = ack; imem_rdata = rd;
        exec_done = done; jump = jmp; jump_addr = ja;
        if (exp_req) begin
            if (ack) begin
                exp_instr = rd; exp_req = 1'b0; exp_ce = 1'b1;
            end
        end else if (exp_ce) begin
            if (done) begin
                exp_pc = jmp ? ja : exp_pc + 8'd1;
                exp_ce = 1'b0;
                exp_req = fe;
            end
        end else if (fe) begin
            exp_req = 1'b1;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        #2 rst_n = 1'b0;
        #1 check_all("reset");
        #5 rst_n = 1'b1;

        // Zero-wait fetch, immediate completion
        cycle("t1a", 1, 0, 16'h0000, 0, 0, 8'h00);
        check("t1_addr", {24'd0, imem_addr}, 32'h0);
        cycle("t1b", 1, 1, 16'h1234, 0, 0, 8'h00);
        check("t1_instr", {16'd0, instr}, 32'h1234);
        check("t1_ce", {31'd0, id_ce}, 32'd1);
        cycle("t1c", 0, 0, 16'h0000, 1, 0, 8'h00);
        check("t1_pc", {24'd0, pc}, 32'd1);
        check("t1_ce_off", {31'd0, id_ce}, 32'd0);

        // Ack delayed three cycles
        cycle("t2a", 1, 0, 16'h0, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            cycle("t2w", 1, 0, 16'hBEEF, 0, 0, 8'h00);
            check("t2_addr_hold", {24'd0, imem_addr}, 32'd1);
        end
        cycle("t2b", 1, 1, 16'h5A5A, 0, 0, 8'h00);

        // Jump to 5, then JUMP alone ignored, then jump to 40
        cycle("t3a", 1, 0, 16'h0, 1, 1, 8'h05);
        cycle("t3b", 1, 1, 16'h7777, 0, 0, 8'h00);
        cycle("t3c", 1, 0, 16'h0, 0, 1, 8'h40);
        check("t3_pc_hold", {24'd0, pc}, 32'h05);
        cycle("t3d", 1, 0, 16'h0, 1, 1, 8'h40);
        check("t3_jaddr", {24'd0, imem_addr}, 32'h40);

        // PC wrap at FF
        cycle("t4a", 1, 1, 16'h1111, 0, 0, 8'h00);
        cycle("t4b", 1, 0, 16'h0, 1, 1, 8'hFF);
        cycle("t4c", 1, 1, 16'h2222, 0, 0, 8'h00);
        cycle("t4d", 1, 0, 16'h0, 1, 0, 8'h00);
        check("t4_wrap", {24'd0, imem_addr}, 32'h00);

        // fetch_en dropped during a wait-state fetch
        cycle("t5a", 0, 0, 16'h0, 0, 0, 8'h00);
        cycle("t5b", 0, 1, 16'hABCD, 0, 0, 8'h00);
        check("t5_instr", {16'd0, instr}, 32'hABCD);
        cycle("t5c", 0, 0, 16'h0, 1, 0, 8'h00);
        check("t5_idle_req", {31'd0, imem_req}, 32'd0);
        cycle("t5d", 0, 1, 16'hFFFF, 1, 0, 8'h00);

        // Reset in the middle of a fetch, then a late ack
        cycle("t6a", 1, 0, 16'h0, 0, 0, 8'h00);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("t6_async");
        fetch_en = 1'b0; imem_ack = 1'b1; imem_rdata = 16'hDEAD;
        @(posedge clk);
        #4 rst_n = 1'b1;
        cycle("t6_late_ack", 0, 1, 16'hDEAD, 0, 0, 8'h00);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [7:0] ja;
            ja = ($urandom_range(0, 7) == 0) ? exp_pc : 8'($urandom);
            cycle("rnd", ($urandom_range(0, 9) != 0), $urandom_range(0, 1) == 1, 16'($urandom),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, ja);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
